// File: rtl/ttc_apb_regif_lite22_if.sv
// ttc_apb_regif_lite22_if: APB bus bundle between the bridge and the TTC register interface.
interface ttc_apb_regif_lite22_if;
   logic        psel22;
   logic        penable22;
   logic        pwrite22;
   logic [7:0]  paddr22;
   logic [31:0] pwdata22;
   logic [31:0] prdata22;
   modport master (output psel22, penable22, pwrite22, paddr22, pwdata22, input prdata22);
   modport slave  (input psel22, penable22, pwrite22, paddr22, pwdata22, output prdata22);
endinterface

// File: rtl/ttc_apb_regif_lite22.sv
// ttc_apb_regif_lite22: APB register decode, write strobes, read mux and read-to-clear for N timers.
module ttc_apb_regif_lite22 #(
   parameter int N_TIMERS = 3
) (
   input  logic                    pclk22,
   input  logic                    n_p_reset22,
   ttc_apb_regif_lite22_if.slave   apb,
   output logic [15:0]             wr_data22,
   output logic [N_TIMERS-1:0]     clk_ctrl_reg_sel22,
   output logic [N_TIMERS-1:0]     cntr_ctrl_reg_sel22,
   output logic [N_TIMERS-1:0]     interval_reg_sel22,
   output logic [N_TIMERS-1:0]     match_1_reg_sel22,
   output logic [N_TIMERS-1:0]     match_2_reg_sel22,
   output logic [N_TIMERS-1:0]     match_3_reg_sel22,
   output logic [N_TIMERS-1:0]     intr_en_reg_sel22,
   output logic [N_TIMERS-1:0]     clear_interrupt22,
   input  logic [7*N_TIMERS-1:0]   clk_ctrl_reg22,
   input  logic [7*N_TIMERS-1:0]   cntr_ctrl_reg22,
   input  logic [16*N_TIMERS-1:0]  counter_val_reg22,
   input  logic [16*N_TIMERS-1:0]  interval_reg22,
   input  logic [16*N_TIMERS-1:0]  match_1_reg22,
   input  logic [16*N_TIMERS-1:0]  match_2_reg22,
   input  logic [16*N_TIMERS-1:0]  match_3_reg22,
   input  logic [6*N_TIMERS-1:0]   interrupt_reg22,
   input  logic [6*N_TIMERS-1:0]   interrupt_en_reg22
);
   logic [5:0]          word;
   logic [3:0]          ri;
   logic [1:0]          ti;
   logic                mapped, writable, wr_acc, rd_acc, rd_set;
   logic [N_TIMERS-1:0] hit;
   logic [31:0]         rd_val;
   // Registers are interleaved per timer: word = 3*reg + timer.
   assign word     = apb.paddr22[7:2];
   assign ri       = 4'(word / 6'd3);
   assign ti       = 2'(word % 6'd3);
   assign mapped   = apb.paddr22[1:0] == 2'b00 && apb.paddr22 <= 8'h68 && int'(ti) < N_TIMERS;
   assign writable = ri != 4'd2 && ri != 4'd7;
   assign hit      = mapped ? N_TIMERS'(1) << ti : '0;
   assign wr_acc   = apb.psel22 && apb.penable22 && apb.pwrite22;
   assign rd_acc   = apb.psel22 && apb.penable22 && !apb.pwrite22;
   assign rd_set   = apb.psel22 && !apb.penable22 && !apb.pwrite22;
   always_comb begin
      rd_val = '0;
      if (mapped)
         case (ri)
            4'd0: rd_val = 32'(clk_ctrl_reg22[7*ti +: 7]);
            4'd1: rd_val = 32'(cntr_ctrl_reg22[7*ti +: 7]);
            4'd2: rd_val = 32'(counter_val_reg22[16*ti +: 16]);
            4'd3: rd_val = 32'(interval_reg22[16*ti +: 16]);
            4'd4: rd_val = 32'(match_1_reg22[16*ti +: 16]);
            4'd5: rd_val = 32'(match_2_reg22[16*ti +: 16]);
            4'd6: rd_val = 32'(match_3_reg22[16*ti +: 16]);
            4'd7: rd_val = 32'(interrupt_reg22[6*ti +: 6]);
            4'd8: rd_val = 32'(interrupt_en_reg22[6*ti +: 6]);
            default: rd_val = '0;
         endcase
   end
   always_ff @(posedge pclk22 or negedge n_p_reset22) begin
      if (!n_p_reset22) begin
         apb.prdata22        <= '0;
         wr_data22           <= '0;
         clk_ctrl_reg_sel22  <= '0;
         cntr_ctrl_reg_sel22 <= '0;
         interval_reg_sel22  <= '0;
         match_1_reg_sel22   <= '0;
         match_2_reg_sel22   <= '0;
         match_3_reg_sel22   <= '0;
         intr_en_reg_sel22   <= '0;
         clear_interrupt22   <= '0;
      end else begin
         clk_ctrl_reg_sel22  <= (wr_acc && ri == 4'd0) ? hit : '0;
         cntr_ctrl_reg_sel22 <= (wr_acc && ri == 4'd1) ? hit : '0;
         interval_reg_sel22  <= (wr_acc && ri == 4'd3) ? hit : '0;
         match_1_reg_sel22   <= (wr_acc && ri == 4'd4) ? hit : '0;
         match_2_reg_sel22   <= (wr_acc && ri == 4'd5) ? hit : '0;
         match_3_reg_sel22   <= (wr_acc && ri == 4'd6) ? hit : '0;
         intr_en_reg_sel22   <= (wr_acc && ri == 4'd8) ? hit : '0;
         clear_interrupt22   <= (rd_acc && ri == 4'd7) ? hit : '0;
         if (wr_acc && mapped && writable)
            wr_data22 <= apb.pwdata22[15:0];
         if (rd_set)
            apb.prdata22 <= rd_val;
      end
   end
endmodule

// File: tb/tb_ttc_apb_regif_lite22.sv
// tb_ttc_apb_regif_lite22: directed APB transfers; a queue scoreboard checks strobes and read data.
module tb_ttc_apb_regif_lite22;
   typedef struct packed {
      logic [23:0] s;
      logic [15:0] wd;
   } exp_t;
   logic        clk = 0;
   logic        rst_n = 0;
   logic [15:0] wr_data;
   logic [2:0]  s_clk, s_cntr, s_intv, s_m1, s_m2, s_m3, s_ien, s_clr;
   logic [20:0] clk_ctrl  = {7'h55, 7'h2A, 7'h13};
   logic [20:0] cntr_ctrl = {7'h11, 7'h22, 7'h33};
   logic [47:0] cval      = {16'h1111, 16'hBEEF, 16'h0001};
   logic [47:0] intv      = {16'hA0A2, 16'hA0A1, 16'hA0A0};
   logic [47:0] m1        = {16'hB002, 16'hB001, 16'hB000};
   logic [47:0] m2        = {16'hC002, 16'hC001, 16'hC000};
   logic [47:0] m3        = {16'hD002, 16'hD001, 16'hD000};
   logic [17:0] intr      = {6'h15, 6'h2A, 6'h01};
   logic [17:0] intr_en   = {6'h3F, 6'h07, 6'h00};
   exp_t        q_s[$];
   logic [31:0] q_r[$];
   logic [15:0] last_wr = '0;
   logic [23:0] mon_s;
   exp_t        e;
   logic [31:0] er;
   int          checks = 0;
   int          errors = 0;
   always #5 clk = ~clk;
   ttc_apb_regif_lite22_if bus();
   ttc_apb_regif_lite22 #(.N_TIMERS(3)) dut (
      .pclk22(clk), .n_p_reset22(rst_n), .apb(bus), .wr_data22(wr_data),
      .clk_ctrl_reg_sel22(s_clk), .cntr_ctrl_reg_sel22(s_cntr), .interval_reg_sel22(s_intv),
      .match_1_reg_sel22(s_m1), .match_2_reg_sel22(s_m2), .match_3_reg_sel22(s_m3),
      .intr_en_reg_sel22(s_ien), .clear_interrupt22(s_clr),
      .clk_ctrl_reg22(clk_ctrl), .cntr_ctrl_reg22(cntr_ctrl), .counter_val_reg22(cval),
      .interval_reg22(intv), .match_1_reg22(m1), .match_2_reg22(m2), .match_3_reg22(m3),
      .interrupt_reg22(intr), .interrupt_en_reg22(intr_en)
   );
   assign mon_s = {s_clk, s_cntr, s_intv, s_m1, s_m2, s_m3, s_ien, s_clr};
   // Field order: 0 clk_ctrl .. 6 intr_en, 7 clear; t is the timer.
   function automatic logic [23:0] sb(input int fld, input int t);
      return 24'(1) << (3 * (7 - fld) + t);
   endfunction
   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", n, got, exp);
      end
   endtask
   task automatic idle();
      @(posedge clk) #1;
      bus.psel22 = 0;
      bus.penable22 = 0;
   endtask
   task automatic xfer(input logic w, input logic [7:0] a, input logic [31:0] d);
      @(posedge clk) #1;
      bus.psel22 = 1;
      bus.penable22 = 0;
      bus.pwrite22 = w;
      bus.paddr22 = a;
      bus.pwdata22 = d;
      @(posedge clk) #1;
      bus.penable22 = 1;
   endtask
   task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [23:0] es);
      if (es != 0) begin
         last_wr = d[15:0];
         q_s.push_back('{es, d[15:0]});
      end
      xfer(1'b1, a, d);
   endtask
   task automatic rd(input logic [7:0] a, input logic [31:0] exp, input logic [23:0] clr);
      q_r.push_back(exp);
      if (clr != 0) q_s.push_back('{clr, last_wr});
      xfer(1'b0, a, 32'h0);
   endtask
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (mon_s != 0) begin
               checks++;
               if (q_s.size() == 0) begin
                  errors++;
                  $display("FAIL strobe unexpected got %h wd %h", mon_s, wr_data);
               end else begin
                  e = q_s.pop_front();
                  if (mon_s !== e.s || wr_data !== e.wd) begin
                     errors++;
                     $display("FAIL strobe got %h wd %h exp %h wd %h", mon_s, wr_data, e.s, e.wd);
                  end
               end
            end
            if (bus.psel22 && bus.penable22 && !bus.pwrite22) begin
               checks++;
               if (q_r.size() == 0) begin
                  errors++;
                  $display("FAIL prdata unexpected read got %h", bus.prdata22);
               end else begin
                  er = q_r.pop_front();
                  if (bus.prdata22 !== er) begin
                     errors++;
                     $display("FAIL prdata addr %h got %h exp %h", bus.paddr22, bus.prdata22, er);
                  end
               end
            end
         end
      end
   end
   initial begin
      logic [31:0] rexp [9];
      rexp = '{32'h13, 32'h33, 32'h0001, 32'hA0A0, 32'hB000, 32'hC000, 32'hD000, 32'h01, 32'h00};
      bus.psel22 = 0;
      bus.penable22 = 0;
      bus.pwrite22 = 0;
      bus.paddr22 = 0;
      bus.pwdata22 = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_prdata", bus.prdata22, 0);
      chk("rst_wr_data", 32'(wr_data), 0);
      chk("rst_strobes", 32'(mon_s), 0);
      rst_n = 1;
      wr(8'h28, 32'h0000_1234, sb(2, 1));
      idle();
      rd(8'h1C, 32'h0000_BEEF, 0);
      idle();
      rd(8'h5C, 32'h15, sb(7, 2));
      idle();
      rd(8'h5C, 32'h15, sb(7, 2));
      idle();
      wr(8'h18, 32'h1111, 0);
      wr(8'h6C, 32'h2222, 0);
      wr(8'h01, 32'h3333, 0);
      rd(8'h6C, 0, 0);
      rd(8'h01, 0, 0);
      idle();
      wr(8'h00, 32'hAAAA, sb(0, 0));
      wr(8'h04, 32'h5555, sb(0, 1));
      rd(8'h00, 32'h13, 0);
      idle();
      for (int k = 0; k < 9; k++) rd(8'(12 * k), rexp[k], k == 7 ? sb(7, 0) : 24'h0);
      idle();
      for (int k = 0; k < 9; k++)
         if (k != 2 && k != 7)
            wr(8'(12 * k + 8), 32'hF000 + 32'(k), sb(k < 2 ? k : (k == 8 ? 6 : k - 1), 2));
      rd(8'h68, 32'h3F, 0);
      rd(8'h20, 32'h1111, 0);
      idle();
      // Access phase with no setup phase still decodes.
      q_s.push_back('{sb(4, 0), 16'h0BAD});
      last_wr = 16'h0BAD;
      @(posedge clk) #1;
      bus.psel22 = 1;
      bus.penable22 = 1;
      bus.pwrite22 = 1;
      bus.paddr22 = 8'h3C;
      bus.pwdata22 = 32'h0BAD;
      idle();
      @(posedge clk) #1;
      bus.psel22 = 1;
      bus.penable22 = 0;
      bus.pwrite22 = 1;
      bus.paddr22 = 8'h00;
      @(posedge clk) #1;
      bus.psel22 = 0;
      bus.penable22 = 1;
      idle();
      @(posedge clk) #1;
      bus.psel22 = 1;
      bus.penable22 = 0;
      bus.pwrite22 = 0;
      bus.paddr22 = 8'h1C;
      @(posedge clk) #1;
      chk("pre_rst_prdata", bus.prdata22, 32'hBEEF);
      #2 rst_n = 0;
      #1;
      chk("async_rst_prdata", bus.prdata22, 0);
      chk("async_rst_wr_data", 32'(wr_data), 0);
      chk("async_rst_strobes", 32'(mon_s), 0);
      bus.psel22 = 0;
      @(posedge clk) #1;
      rst_n = 1;
      last_wr = 0;
      rd(8'h5C, 32'h15, sb(7, 2));
      wr(8'h30, 32'hFFFF_00FF, sb(3, 0));
      idle();
      repeat (3) @(posedge clk);
      #1;
      chk("strobe_queue_left", 32'(q_s.size()), 0);
      chk("read_queue_left", 32'(q_r.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ttc_apb_regif_lite22.md
Name: ttc_apb_regif_lite22

Overview:
APB slave register interface for the lite triple timer/counter (TTC). Decodes APB accesses into one-hot write-select strobes and a registered write-data bus for N timer/counter instances. Muxes their register outputs back onto a registered prdata bus, and generates a read-to-clear pulse for each timer's interrupt register. Sits between the APB bridge and the timer/counter instances.

Parameters:
N_TIMERS, 3, number of timer/counter instances served (1..3); offsets i >= N_TIMERS decode as unmapped.

Ports:
pclk22 input 1 APB system clock
n_p_reset22 input 1 reset; asynchronous assert, active-low
psel22 input 1 APB select
penable22 input 1 APB enable (access phase)
pwrite22 input 1 APB write
paddr22 input 8 byte address
pwdata22 input 32 APB write data
prdata22 output 32 registered read data
wr_data22 output 16 registered pwdata22[15:0], valid while any strobe is high
clk_ctrl_reg_sel22 output N_TIMERS write strobe, clock-control register
cntr_ctrl_reg_sel22 output N_TIMERS write strobe, counter-control register
interval_reg_sel22 output N_TIMERS write strobe, interval register
match_1_reg_sel22 output N_TIMERS write strobe, match 1 register
match_2_reg_sel22 output N_TIMERS write strobe, match 2 register
match_3_reg_sel22 output N_TIMERS write strobe, match 3 register
intr_en_reg_sel22 output N_TIMERS write strobe, interrupt-enable register
clear_interrupt22 output N_TIMERS read-clear pulse, interrupt register
clk_ctrl_reg22 input 7*N_TIMERS per-timer readback, packed; timer i at [7i+6:7i]
cntr_ctrl_reg22 input 7*N_TIMERS per-timer readback, packed
counter_val_reg22 input 16*N_TIMERS per-timer readback, packed
interval_reg22 input 16*N_TIMERS per-timer readback, packed
match_1_reg22 input 16*N_TIMERS per-timer readback, packed
match_2_reg22 input 16*N_TIMERS per-timer readback, packed
match_3_reg22 input 16*N_TIMERS per-timer readback, packed
interrupt_reg22 input 6*N_TIMERS per-timer readback, packed
interrupt_en_reg22 input 6*N_TIMERS per-timer readback, packed

Behaviour:
- Reset: n_p_reset22 is asynchronous and active-low. While it is low, prdata22=0, wr_data22=0, and all strobes and clear pulses are 0. All state is in pclk22 flops.
- Address map: base + 4*i, timer i = 0..N_TIMERS-1.
  - clk_ctrl 0x00 RW
  - cntr_ctrl 0x0C RW
  - counter_val 0x18 RO
  - interval 0x24 RW
  - match_1 0x30 RW
  - match_2 0x3C RW
  - match_3 0x48 RW
  - interrupt 0x54 RO, read-to-clear
  - intr_en 0x60 RW
- Unmapped: paddr22[1:0]!=0, paddr22>0x68, and i>=N_TIMERS. Unmapped reads return 0; unmapped writes are ignored. Writes to RO registers are ignored with no strobe.
- Write:
  - Access phase is psel22&penable22&pwrite22 at edge T.
  - On T+1, exactly one matching strobe bit is high for one cycle, and wr_data22=pwdata22[15:0].
  - wr_data22 holds its last value otherwise.
  - At most one strobe bit across all outputs is ever high.
- Read:
  - Setup phase is psel22&!penable22&!pwrite22 at edge T.
  - prdata22 is loaded at T with the zero-extended register value and is stable through the access phase.
  - prdata22 holds until the next read setup phase. Writes do not alter prdata22.
- Read-clear:
  - An access-phase read of interrupt reg i at edge T pulses clear_interrupt22[i] high for the single cycle T+1.
  - The captured prdata22 is the pre-clear value.
- Back-to-back transfers: a setup phase may immediately follow an access phase. Strobes and pulses are still exactly one cycle each; there is no merging.
- Protocol anomalies:
  - penable22 high without a preceding setup phase: still decoded as access (no protocol checking).
  - psel22 dropped mid-transfer: nothing fires.
- Reset asserted mid-transfer: outputs go to 0 immediately. The transfer is lost and no strobe is emitted after reset release.
- Latency: write-to-strobe 1 cycle; read data valid at the access phase (0 wait states).

Test Plan:
- Reset: assert n_p_reset22 low mid-read -> prdata22=0x0 and all strobes 0 within the same cycle, asynchronously.
- Write 0x0000_1234 to 0x28 -> interval_reg_sel22=3'b010 for exactly one cycle, wr_data22=0x1234, all other strobes 0.
- Read 0x1C with counter_val_reg22[31:16]=0xBEEF -> prdata22=0x0000BEEF during the access phase.
- Read 0x5C with interrupt_reg22[17:12]=6'h15 -> prdata22=0x15 and clear_interrupt22=3'b100 for one cycle. A second read is not pulsed unless it is a new access.
- Write 0x18 (RO), write 0x6C (unmapped), and write 0x01 (misaligned) -> no strobe. Reads of 0x6C and 0x01 return 0.
- Back-to-back: write 0x00, then write 0x04, then read 0x00 in consecutive transfers -> clk_ctrl_reg_sel22 = 001 then 010 on separate single cycles, and prdata22 = zero-extended clk_ctrl_reg22[6:0].
